// File: rtl/spi_reg_bank.sv
`default_nettype none
// =============================================================================
// spi_reg_bank - SPI-slave register bank with burst read/write, all on iclk
// Rev 1.0
// =============================================================================
module spi_reg_bank #(
  parameter int                        NUM_REGS    = 8,
  parameter int                        REG_W       = 8,
  parameter int                        ADDR_W      = 7,
  parameter int                        SYNC_STAGES = 2,
  parameter bit                        LSB_FIRST   = 1'b1,
  parameter logic [NUM_REGS*REG_W-1:0] RESET_VALS  = '0
) (
  input  logic                      iclk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      csn,
  input  logic                      serial_in,
  output logic                      serial_out,
  output logic                      serial_oe,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]       wr_pulse,
  output logic                      addr_err,
  output logic                      busy
);

  localparam int c_HDR_W = ADDR_W + 1;
  localparam int c_CUR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int c_MAXW  = (c_HDR_W > REG_W) ? c_HDR_W : REG_W;
  localparam int c_CNT_W = $clog2(c_MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_sdi_sync;
  logic                   r_sclk_prev, r_csn_prev;
  logic [c_CNT_W-1:0]     r_bit_cnt;
  logic [c_HDR_W-1:0]     r_hdr;
  logic [REG_W-1:0]       r_rx, r_tx, r_wdata;
  logic [c_CUR_W-1:0]     r_cur, r_wsel;
  logic                   r_commit, r_rd_armed;
  logic [REG_W-1:0]       r_regs [NUM_REGS];

  logic                   w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall, w_sdi;
  logic [c_HDR_W-1:0]     w_hdr_next;
  logic [ADDR_W-1:0]      w_hdr_addr;
  logic                   w_hdr_rw, w_hdr_done, w_addr_bad, w_drive;
  logic [REG_W-1:0]       w_rx_next, w_tx_shift;
  logic                   w_tx_bit;
  logic [c_CUR_W-1:0]     w_cur_inc, w_hdr_sel;

  // csn chain resets low: a frame cut by rst cannot resume until csn is seen high again
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_csn_sync  <= '0;
      r_sdi_sync  <= '0;
      r_sclk_prev <= 1'b0;
      r_csn_prev  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], serial_in};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_csn_prev  <= r_csn_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign w_csn_rise  = r_csn_sync[SYNC_STAGES-1] & ~r_csn_prev;
  assign w_csn_fall  = ~r_csn_sync[SYNC_STAGES-1] & r_csn_prev;
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];

  assign w_hdr_next = LSB_FIRST ? {w_sdi, r_hdr[c_HDR_W-1:1]} : {r_hdr[c_HDR_W-2:0], w_sdi};
  assign w_rx_next  = LSB_FIRST ? {w_sdi, r_rx[REG_W-1:1]}    : {r_rx[REG_W-2:0], w_sdi};
  assign w_tx_shift = LSB_FIRST ? {1'b0, r_tx[REG_W-1:1]}     : {r_tx[REG_W-2:0], 1'b0};
  assign w_tx_bit   = LSB_FIRST ? r_tx[0] : r_tx[REG_W-1];

  assign w_hdr_rw   = w_hdr_next[ADDR_W];
  assign w_hdr_addr = w_hdr_next[ADDR_W-1:0];
  assign w_hdr_sel  = w_hdr_addr[c_CUR_W-1:0];
  assign w_hdr_done = (r_state == S_HDR) && w_sclk_rise &&
                      (r_bit_cnt == c_CNT_W'(c_HDR_W - 1));
  assign w_addr_bad = ({{(32-ADDR_W){1'b0}}, w_hdr_addr} >= 32'(NUM_REGS));
  assign w_cur_inc  = (r_cur == c_CUR_W'(NUM_REGS - 1)) ? '0 : r_cur + 1'b1;
  assign w_drive    = (r_state == S_RD) && !w_csn_rise;

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_csn_fall) w_state_next = S_HDR;
      S_HDR:   if (w_hdr_done) w_state_next = w_addr_bad ? S_SKIP : (w_hdr_rw ? S_RD : S_WR);
      default: w_state_next = r_state;
    endcase
    if (w_csn_rise) w_state_next = S_IDLE;
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_hdr      <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_cur      <= '0;
      r_wsel     <= '0;
      r_wdata    <= '0;
      r_commit   <= 1'b0;
      r_rd_armed <= 1'b0;
      addr_err   <= 1'b0;
      serial_oe  <= 1'b0;
      serial_out <= 1'b0;
    end else begin
      r_commit   <= 1'b0;
      addr_err   <= w_hdr_done & w_addr_bad;
      serial_oe  <= w_drive;
      serial_out <= w_drive ? w_tx_bit : 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bit_cnt  <= '0;
          r_rd_armed <= 1'b0;
        end
        S_HDR: if (w_sclk_rise) begin
          r_hdr <= w_hdr_next;
          if (w_hdr_done) begin
            r_bit_cnt <= '0;
            r_cur     <= w_hdr_sel;
            r_tx      <= r_regs[w_hdr_sel];
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        // Sampling continues in the cycle csn rise is seen, so a just-completed word still commits
        S_WR: if (w_sclk_rise) begin
          r_rx <= w_rx_next;
          if (r_bit_cnt == c_CNT_W'(REG_W - 1)) begin
            r_bit_cnt <= '0;
            r_commit  <= 1'b1;
            r_wsel    <= r_cur;
            r_wdata   <= w_rx_next;
            r_cur     <= w_cur_inc;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        // Only a fall that follows a data rise advances; the fall right after the header is skipped
        S_RD: begin
          if (w_sclk_rise) begin
            r_rd_armed <= 1'b1;
          end else if (w_sclk_fall && r_rd_armed) begin
            r_rd_armed <= 1'b0;
            if (r_bit_cnt == c_CNT_W'(REG_W - 1)) begin
              r_bit_cnt <= '0;
              r_cur     <= w_cur_inc;
              r_tx      <= r_regs[w_cur_inc];
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= w_tx_shift;
            end
          end
        end
        default: r_rd_armed <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VALS[k*REG_W +: REG_W];
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (r_commit) begin
        r_regs[r_wsel]   <= r_wdata;
        wr_pulse[r_wsel] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*REG_W +: REG_W] = r_regs[k];
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// tb_spi_reg_bank - table-driven and randomized frames checked against a register-array model
module tb_spi_reg_bank;
  localparam int NR   = 8;
  localparam int RW   = 8;
  localparam int AW   = 7;
  localparam int SS   = 2;
  localparam int HALF = 6;
  localparam logic [NR*RW-1:0] RV = 64'h0000_0000_3C00_0000;

  logic iclk = 1'b0, rst = 1'b1, sclk = 1'b0, csn = 1'b1, serial_in = 1'b0;
  logic serial_out, serial_oe, addr_err, busy;
  logic [NR*RW-1:0] regs_flat;
  logic [NR-1:0]    wr_pulse;

  spi_reg_bank #(
    .NUM_REGS(NR), .REG_W(RW), .ADDR_W(AW), .SYNC_STAGES(SS),
    .LSB_FIRST(1'b1), .RESET_VALS(RV)
  ) dut (
    .iclk(iclk), .rst(rst), .sclk(sclk), .csn(csn), .serial_in(serial_in),
    .serial_out(serial_out), .serial_oe(serial_oe), .regs_flat(regs_flat),
    .wr_pulse(wr_pulse), .addr_err(addr_err), .busy(busy)
  );

  always #5 iclk = ~iclk;

  int tests = 0, fails = 0;
  int mon_wr_cycles = 0, mon_err = 0;
  int mon_bits [NR];
  initial for (int k = 0; k < NR; k++) mon_bits[k] = 0;

  always @(negedge iclk) begin
    if (wr_pulse != '0) mon_wr_cycles++;
    for (int k = 0; k < NR; k++) if (wr_pulse[k]) mon_bits[k]++;
    if (addr_err) mon_err++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] model [NR];
  logic [7:0] fr_wd [4];
  logic [7:0] fr_rd [4];
  int fr_oe_hdr, fr_oe_data;
  logic fr_busy;

  typedef struct {
    logic             rw;
    int               addr;
    int               nwords;
    logic [2:0][7:0]  d;
    int               abort_bits;
    int               exp_pulses;
    logic [7:0]       exp_mask;
    int               exp_err;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) model[k] = RV[k*RW +: RW];
  endtask

  function automatic logic [NR*RW-1:0] model_flat();
    logic [NR*RW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*RW +: RW] = model[k];
    return f;
  endfunction

  // Master drives MOSI while sclk is low, samples MISO just before raising sclk (mode 0)
  task automatic send_bit(input logic b, output logic miso, output logic oe, output logic bz);
    serial_in = b;
    repeat (HALF) @(negedge iclk);
    miso = serial_out;
    oe   = serial_oe;
    bz   = busy;
    sclk = 1'b1;
    repeat (HALF) @(negedge iclk);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input logic rw, input int addr, input int nwords, input int abort_bits);
    logic [7:0] hdr;
    logic m, o, bz;
    int nb;
    hdr = {rw, 7'(addr)};
    fr_oe_hdr = 0;
    fr_oe_data = 0;
    csn = 1'b0;
    repeat (HALF + 2) @(negedge iclk);
    for (int i = 0; i < 8; i++) begin
      send_bit(hdr[i], m, o, bz);
      if (o) fr_oe_hdr++;
      if (i == 0) fr_busy = bz;
    end
    for (int w = 0; w < nwords; w++) begin
      nb = (abort_bits > 0 && w == nwords - 1) ? abort_bits : 8;
      for (int b = 0; b < nb; b++) begin
        send_bit(fr_wd[w][b], m, o, bz);
        fr_rd[w][b] = m;
        if (o) fr_oe_data++;
      end
    end
    repeat (HALF) @(negedge iclk);
    csn = 1'b1;
    repeat (3 * HALF) @(negedge iclk);
  endtask

  task automatic apply_and_check(input string nm, input logic rw, input int addr, input int nwords,
                                 input int abort_bits, input int exp_pulses,
                                 input logic [7:0] exp_mask, input int exp_err);
    int good, nfull, wr0, err0;
    int b0 [NR];
    logic [7:0] exp_rd [4];
    logic [NR-1:0] got_mask;
    good  = (addr < NR) ? 1 : 0;
    nfull = (abort_bits > 0) ? nwords - 1 : nwords;
    wr0   = mon_wr_cycles;
    err0  = mon_err;
    for (int k = 0; k < NR; k++) b0[k] = mon_bits[k];
    for (int w = 0; w < 4; w++) exp_rd[w] = 8'h00;
    if (good == 1) begin
      for (int w = 0; w < nfull; w++) begin
        exp_rd[w] = model[(addr + w) % NR];
        if (!rw) model[(addr + w) % NR] = fr_wd[w];
      end
    end
    run_frame(rw, addr, nwords, abort_bits);
    for (int k = 0; k < NR; k++) got_mask[k] = (mon_bits[k] != b0[k]);
    check({nm, "_regs"}, regs_flat, model_flat());
    check({nm, "_wr_pulses"}, mon_wr_cycles - wr0, exp_pulses);
    check({nm, "_wr_mask"}, got_mask, exp_mask);
    check({nm, "_addr_err"}, mon_err - err0, exp_err);
    check({nm, "_oe_in_hdr"}, fr_oe_hdr, 0);
    check({nm, "_oe_in_data"}, fr_oe_data, (rw && good == 1) ? nfull * 8 + abort_bits : 0);
    check({nm, "_busy_in_frame"}, fr_busy, 1'b1);
    check({nm, "_busy_after"}, busy, 1'b0);
    check({nm, "_oe_after"}, serial_oe, 1'b0);
    if (rw && good == 1)
      for (int w = 0; w < nfull; w++) check({nm, "_miso_word"}, fr_rd[w], exp_rd[w]);
  endtask

  initial begin
    logic [7:0] hdr, d, old;
    logic m, o, bz;
    int wr0;
    logic rw;
    int addr, nw, ab, good, nfull, pulses, err;
    logic [7:0] mask;

    vecs[0] = '{1'b0,   2, 1, 24'h0000A5, 0, 1, 8'h04, 0};  // single write
    vecs[1] = '{1'b0,   7, 3, 24'h332211, 0, 3, 8'h83, 0};  // burst wraps 7->0->1
    vecs[2] = '{1'b0,   5, 2, 24'h006B5A, 0, 2, 8'h60, 0};  // reg5/reg6 for read-back
    vecs[3] = '{1'b1,   5, 2, 24'h000000, 0, 0, 8'h00, 0};  // read 5A then 6B
    vecs[4] = '{1'b0,   1, 1, 24'h0000FF, 4, 0, 8'h00, 0};  // abort after 4 bits
    vecs[5] = '{1'b0,   9, 1, 24'h0000EE, 0, 0, 8'h00, 1};  // out-of-range write
    vecs[6] = '{1'b1, 100, 1, 24'h000000, 0, 0, 8'h00, 1};  // out-of-range read
    vecs[7] = '{1'b1,   7, 2, 24'h000000, 0, 0, 8'h00, 0};  // read wraps 7->0
    vecs[8] = '{1'b0,   3, 2, 24'h0096C3, 3, 1, 8'h08, 0};  // second word aborted

    // Reset state
    model_reset();
    repeat (3) @(negedge iclk);
    check("reset_regs", regs_flat, RV);
    check("reset_serial_out", serial_out, 1'b0);
    check("reset_serial_oe", serial_oe, 1'b0);
    check("reset_wr_pulse", wr_pulse, 8'h00);
    check("reset_addr_err", addr_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge iclk);

    for (int i = 0; i < 9; i++) begin
      for (int w = 0; w < 3; w++) fr_wd[w] = vecs[i].d[w];
      fr_wd[3] = 8'h00;
      apply_and_check($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].nwords,
                      vecs[i].abort_bits, vecs[i].exp_pulses, vecs[i].exp_mask, vecs[i].exp_err);
    end

    // Exact write latency: register visible SYNC_STAGES+2 iclk after the last sclk rise
    old = model[2];
    d   = 8'h5C;
    hdr = {1'b0, 7'd2};
    csn = 1'b0;
    repeat (HALF + 2) @(negedge iclk);
    for (int i = 0; i < 8; i++) send_bit(hdr[i], m, o, bz);
    for (int b = 0; b < 7; b++) send_bit(d[b], m, o, bz);
    serial_in = d[7];
    repeat (HALF) @(negedge iclk);
    sclk = 1'b1;
    repeat (SS + 1) @(posedge iclk);
    #1;
    check("latency_before", regs_flat[23:16], old);
    check("latency_no_pulse_yet", wr_pulse, 8'h00);
    @(posedge iclk);
    #1;
    check("latency_after", regs_flat[23:16], 8'h5C);
    check("latency_pulse", wr_pulse, 8'h04);
    @(posedge iclk);
    #1;
    check("latency_pulse_width", wr_pulse, 8'h00);
    @(negedge iclk);
    repeat (HALF) @(negedge iclk);
    sclk = 1'b0;
    repeat (HALF) @(negedge iclk);
    csn = 1'b1;
    repeat (3 * HALF) @(negedge iclk);
    model[2] = 8'h5C;
    check("latency_regs", regs_flat, model_flat());

    // Randomized frames
    for (int t = 0; t < 20; t++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 11);
      nw   = $urandom_range(1, 3);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int w = 0; w < 4; w++) fr_wd[w] = 8'($urandom);
      good   = (addr < NR) ? 1 : 0;
      nfull  = (ab > 0) ? nw - 1 : nw;
      pulses = (good == 1 && !rw) ? nfull : 0;
      err    = 1 - good;
      mask   = 8'h00;
      if (good == 1 && !rw)
        for (int w = 0; w < nfull; w++) mask[(addr + w) % NR] = 1'b1;
      apply_and_check($sformatf("rand%0d", t), rw, addr, nw, ab, pulses, mask, err);
    end

    // rst in the middle of a write frame; the rest of that frame must be ignored
    hdr = {1'b0, 7'd0};
    wr0 = mon_wr_cycles;
    csn = 1'b0;
    repeat (HALF + 2) @(negedge iclk);
    for (int i = 0; i < 8; i++) send_bit(hdr[i], m, o, bz);
    for (int b = 0; b < 3; b++) send_bit(1'b1, m, o, bz);
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_regs", regs_flat, RV);
    check("midrst_busy", busy, 1'b0);
    check("midrst_oe", serial_oe, 1'b0);
    check("midrst_wr_pulse", wr_pulse, 8'h00);
    @(negedge iclk);
    rst = 1'b0;
    for (int b = 0; b < 13; b++) send_bit(1'b1, m, o, bz);
    repeat (HALF) @(negedge iclk);
    csn = 1'b1;
    repeat (3 * HALF) @(negedge iclk);
    check("midrst_frame_lost_regs", regs_flat, RV);
    check("midrst_frame_lost_pulses", mon_wr_cycles - wr0, 0);

    // A fresh frame after the reset works again
    fr_wd[0] = 8'h77;
    apply_and_check("post_rst", 1'b0, 4, 1, 0, 1, 8'h10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
